// File: rtl/axi_proxy_mc_if.sv
// rtl/axi_proxy_mc_if.sv - bus bundle for axi_proxy_mc: request/response streams and ASHI register port
interface axi_proxy_mc_if #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 512,
  parameter int IN_W   = 256
);
  logic [OUT_W-1:0]  AXIS_OUT_TDATA;
  logic [NUM_CH-1:0] AXIS_OUT_TVALID;
  logic [NUM_CH-1:0] AXIS_OUT_TLAST;
  logic [NUM_CH-1:0] AXIS_OUT_TREADY;
  logic [IN_W-1:0]   AXIS_IN_TDATA;
  logic              AXIS_IN_TVALID;
  logic              AXIS_IN_TREADY;
  logic [31:0]       ashi_waddr;
  logic [31:0]       ashi_wdata;
  logic              ashi_write;
  logic [1:0]        ashi_wresp;
  logic              ashi_widle;
  logic [31:0]       ashi_raddr;
  logic              ashi_read;
  logic [31:0]       ashi_rdata;
  logic [1:0]        ashi_rresp;
  logic              ashi_ridle;

  // Proxy side: answers ASHI accesses, drives requests, consumes responses
  modport slave (
    output AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
    input  AXIS_OUT_TREADY,
    input  AXIS_IN_TDATA, AXIS_IN_TVALID,
    output AXIS_IN_TREADY,
    input  ashi_waddr, ashi_wdata, ashi_write,
    output ashi_wresp, ashi_widle,
    input  ashi_raddr, ashi_read,
    output ashi_rdata, ashi_rresp, ashi_ridle
  );

  // Environment side: issues ASHI accesses, accepts requests, returns responses
  modport master (
    input  AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST,
    output AXIS_OUT_TREADY,
    output AXIS_IN_TDATA, AXIS_IN_TVALID,
    input  AXIS_IN_TREADY,
    output ashi_waddr, ashi_wdata, ashi_write,
    input  ashi_wresp, ashi_widle,
    output ashi_raddr, ashi_read,
    input  ashi_rdata, ashi_rresp, ashi_ridle
  );
endinterface

// File: rtl/axi_proxy_mc.sv
// rtl/axi_proxy_mc.sv - multi-channel ASHI-to-stream proxy with tagged responses and timeout
module axi_proxy_mc #(
  parameter int          NUM_CH          = 2,
  parameter int          OUT_W           = 512,
  parameter int          IN_W            = 256,
  parameter logic [7:0]  PKT_TYPE        = 8'h01,
  parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1_000_000,
  parameter logic [31:0] PRELOAD_ADDR    = 32'h0000_1000,
  parameter logic [31:0] PRELOAD_VALU    = 32'h0000_000F
) (
  input logic            clk,
  input logic            reset,
  input logic            preload_complete,
  axi_proxy_mc_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;

  state_t            state;
  logic [31:0]       addr_reg;
  logic [NUM_CH-1:0] ch_mask;
  logic [31:0]       timeout_reg;
  logic [2:0]        status_resp;
  logic              sticky_to;
  logic              sticky_stale;
  logic [7:0]        status_tag;
  logic [7:0]        tag;
  logic [OUT_W-1:0]  tdata;
  logic [NUM_CH-1:0] tvalid;
  logic              in_tready;
  logic              pending;
  logic              cur_rd;
  logic              cur_pre;
  logic [31:0]       tcnt;
  logic [1:0]        wresp;
  logic [1:0]        rresp;
  logic [31:0]       rdata;

  logic [4:0]        widx;
  logic [4:0]        ridx;
  logic              is_idle;
  logic              pre_service;
  logic              launch_req;
  logic              launch_rd;
  logic [31:0]       launch_addr;
  logic [31:0]       launch_data;
  logic              mask_zero;
  logic              resp_hs;
  logic              resp_match;
  logic              expired;
  logic [NUM_CH-1:0] tvalid_left;
  logic [31:0]       status_word;
  logic              unused_ok;

  assign widx      = bus.ashi_waddr[6:2];
  assign ridx      = bus.ashi_raddr[6:2];
  assign is_idle   = (state == IDLE);
  assign mask_zero = (ch_mask == '0);

  // Preload only gets the IDLE slot when neither ASHI side is asking
  assign pre_service = is_idle && !bus.ashi_write && !bus.ashi_read && pending;
  assign launch_rd   = !bus.ashi_write && bus.ashi_read;
  assign launch_req  = is_idle && ((bus.ashi_write && widx == 5'd1) ||
                                   (launch_rd && ridx == 5'd1) || pre_service);
  assign launch_addr = pre_service ? PRELOAD_ADDR : addr_reg;
  assign launch_data = pre_service ? PRELOAD_VALU : (launch_rd ? 32'h0 : bus.ashi_wdata);

  assign resp_hs     = bus.AXIS_IN_TVALID && in_tready;
  assign resp_match  = resp_hs && (bus.AXIS_IN_TDATA[79:72] == tag);
  assign expired     = (timeout_reg != 32'd0) && (({1'b0, tcnt} + 33'd1) >= {1'b0, timeout_reg});
  assign tvalid_left = tvalid & ~bus.AXIS_OUT_TREADY;
  assign status_word = {8'h00, status_tag, 6'h00, sticky_stale, sticky_to, 5'h00, status_resp};

  assign bus.AXIS_OUT_TDATA  = tdata;
  assign bus.AXIS_OUT_TVALID = tvalid;
  assign bus.AXIS_OUT_TLAST  = '1;
  assign bus.AXIS_IN_TREADY  = in_tready;
  assign bus.ashi_wresp      = wresp;
  assign bus.ashi_rresp      = rresp;
  assign bus.ashi_rdata      = rdata;
  assign bus.ashi_widle      = !bus.ashi_write && is_idle;
  assign bus.ashi_ridle      = !bus.ashi_read && is_idle;

  assign unused_ok = ^{bus.ashi_waddr[31:7], bus.ashi_waddr[1:0], bus.ashi_raddr[31:7],
                       bus.ashi_raddr[1:0], bus.AXIS_IN_TDATA[IN_W-1:80],
                       bus.AXIS_IN_TDATA[71:67], bus.AXIS_IN_TDATA[31:0]};

  function automatic logic [OUT_W-1:0] build_pkt(input logic [31:0] a, input logic [31:0] d,
                                                 input logic rd, input logic [7:0] t);
    logic [OUT_W-1:0] p;
    p              = '0;
    p[31:0]        = a;
    p[63:32]       = d;
    p[64]          = rd;
    p[79:72]       = t;
    p[OUT_W-1 -: 8] = PKT_TYPE;
    return p;
  endfunction

  // Register file, request FSM, response/timeout handling and preload queueing
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_reg     <= 32'h0;
      ch_mask      <= '1;
      timeout_reg  <= TIMEOUT_DEFAULT;
      status_resp  <= 3'd0;
      sticky_to    <= 1'b0;
      sticky_stale <= 1'b0;
      status_tag   <= 8'd0;
      tag          <= 8'd0;
      tdata        <= '0;
      tvalid       <= '0;
      in_tready    <= 1'b0;
      pending      <= 1'b0;
      cur_rd       <= 1'b0;
      cur_pre      <= 1'b0;
      tcnt         <= 32'd0;
      wresp        <= OKAY;
      rresp        <= OKAY;
      rdata        <= 32'h0;
    end else begin
      pending <= preload_complete || (pending && !pre_service);
      case (state)
        IDLE: begin
          if (launch_req) begin
            if (mask_zero) begin
              if (pre_service) begin
                status_resp <= 3'd2;
              end else if (launch_rd) begin
                rresp <= SLVERR;
                rdata <= 32'h0;
              end else begin
                wresp <= SLVERR;
              end
            end else begin
              tag     <= tag + 8'd1;
              tdata   <= build_pkt(launch_addr, launch_data, launch_rd && !pre_service, tag + 8'd1);
              tvalid  <= ch_mask;
              cur_rd  <= launch_rd && !pre_service;
              cur_pre <= pre_service;
              state   <= SEND;
            end
          end else if (bus.ashi_write) begin
            wresp <= OKAY;
            case (widx)
              5'd0: addr_reg <= bus.ashi_wdata;
              5'd2: ch_mask <= bus.ashi_wdata[NUM_CH-1:0];
              5'd3: begin
                if (bus.ashi_wdata[31]) begin
                  sticky_to    <= 1'b0;
                  sticky_stale <= 1'b0;
                end
              end
              5'd4: timeout_reg <= bus.ashi_wdata;
              default: wresp <= SLVERR;
            endcase
          end else if (bus.ashi_read) begin
            rresp <= OKAY;
            case (ridx)
              5'd0: rdata <= addr_reg;
              5'd2: rdata <= 32'(ch_mask);
              5'd3: rdata <= status_word;
              5'd4: rdata <= timeout_reg;
              default: rresp <= SLVERR;
            endcase
          end
        end
        SEND: begin
          tvalid <= tvalid_left;
          if (tvalid_left == '0) begin
            in_tready <= 1'b1;
            tcnt      <= 32'd0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          tcnt <= tcnt + 32'd1;
          if (resp_match) begin
            in_tready   <= 1'b0;
            state       <= IDLE;
            status_resp <= bus.AXIS_IN_TDATA[66:64];
            status_tag  <= tag;
            if (!cur_pre) begin
              if (cur_rd) begin
                rresp <= bus.AXIS_IN_TDATA[65:64];
                rdata <= bus.AXIS_IN_TDATA[63:32];
              end else begin
                wresp <= bus.AXIS_IN_TDATA[65:64];
              end
            end
          end else begin
            if (resp_hs) sticky_stale <= 1'b1;
            if (expired) begin
              in_tready   <= 1'b0;
              state       <= IDLE;
              status_resp <= 3'd2;
              sticky_to   <= 1'b1;
              if (!cur_pre) begin
                if (cur_rd) begin
                  rresp <= SLVERR;
                  rdata <= 32'hDEAD_DEAD;
                end else begin
                  wresp <= SLVERR;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_proxy_mc.sv
// tb/tb_axi_proxy_mc.sv - self-checking bench for axi_proxy_mc
module tb_axi_proxy_mc;
  localparam int          NUM_CH = 2;
  localparam int          OUT_W  = 512;
  localparam int          IN_W   = 256;
  localparam logic [31:0] TO_DEF = 32'd1_000_000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload_complete = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  axi_proxy_mc_if #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .IN_W(IN_W)) bus ();

  axi_proxy_mc #(.NUM_CH(NUM_CH), .OUT_W(OUT_W), .IN_W(IN_W)) dut (
    .clk(clk), .reset(reset), .preload_complete(preload_complete), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  resp;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[16];

  // Reference model state
  logic [31:0]       m_addr, m_timeout, m_rdata;
  logic [NUM_CH-1:0] m_mask;
  logic [7:0]        m_tag, m_stag;
  logic [2:0]        m_sresp;
  bit                m_to, m_stale;
  logic [1:0]        m_wresp, m_rresp;

  logic [OUT_W-1:0]  req_d;
  logic [NUM_CH-1:0] req_v;
  int                req_cyc;
  bit                req_stable;
  logic [31:0]       rv, a, d, rnd;
  logic [1:0]        rr;
  int                cnt;
  bit                flag;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [OUT_W-1:0] exp_pkt(input logic [31:0] ad, input logic [31:0] dd,
                                               input bit rd, input logic [7:0] t);
    logic [OUT_W-1:0] p = '0;
    p[31:0]         = ad;
    p[63:32]        = rd ? 32'h0 : dd;
    p[64]           = rd;
    p[79:72]        = t;
    p[OUT_W-1 -: 8] = 8'h01;
    return p;
  endfunction

  function automatic logic [31:0] m_status();
    return {8'h00, m_stag, 6'h00, m_stale, m_to, 5'h00, m_sresp};
  endfunction

  task automatic model_reset();
    m_addr = 0; m_timeout = TO_DEF; m_rdata = 0; m_mask = '1; m_tag = 0; m_stag = 0;
    m_sresp = 0; m_to = 0; m_stale = 0; m_wresp = 0; m_rresp = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.ashi_widle && bus.ashi_ridle) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail("idle_wait");
  endtask

  task automatic wr_strobe(input logic [31:0] ad, input logic [31:0] dd);
    bus.ashi_waddr = ad;
    bus.ashi_wdata = dd;
    bus.ashi_write = 1'b1;
    @(negedge clk);
    bus.ashi_write = 1'b0;
  endtask

  task automatic rd_strobe(input logic [31:0] ad);
    bus.ashi_raddr = ad;
    bus.ashi_read  = 1'b1;
    @(negedge clk);
    bus.ashi_read  = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] ad, input logic [31:0] dd);
    wait_idle();
    wr_strobe(ad, dd);
    wait_idle();
  endtask

  task automatic reg_rd(input logic [31:0] ad, output logic [31:0] v, output logic [1:0] r);
    wait_idle();
    rd_strobe(ad);
    wait_idle();
    v = bus.ashi_rdata;
    r = bus.ashi_rresp;
  endtask

  task automatic get_req(output logic [OUT_W-1:0] dd, output logic [NUM_CH-1:0] v,
                         output int cyc, output bit stable);
    int n = 0;
    logic [NUM_CH-1:0] prev;
    dd = '0; v = '0; cyc = 0; stable = 1'b1;
    while (bus.AXIS_OUT_TVALID == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      bound_fail("req_wait");
      return;
    end
    dd = bus.AXIS_OUT_TDATA;
    v = bus.AXIS_OUT_TVALID;
    prev = v;
    while (bus.AXIS_OUT_TVALID != '0 && cyc < 1000) begin
      if (bus.AXIS_OUT_TDATA !== dd) stable = 1'b0;
      if ((bus.AXIS_OUT_TVALID & ~prev) != '0) stable = 1'b0;
      prev = bus.AXIS_OUT_TVALID;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 1000) bound_fail("req_drain");
  endtask

  task automatic send_resp(input logic [7:0] t, input logic [2:0] r, input logic [31:0] dd);
    int n = 0;
    while (!bus.AXIS_IN_TREADY && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      bound_fail("resp_ready_wait");
      return;
    end
    bus.AXIS_IN_TDATA          = '0;
    bus.AXIS_IN_TDATA[63:32]   = dd;
    bus.AXIS_IN_TDATA[66:64]   = r;
    bus.AXIS_IN_TDATA[79:72]   = t;
    bus.AXIS_IN_TVALID         = 1'b1;
    @(negedge clk);
    bus.AXIS_IN_TVALID         = 1'b0;
  endtask

  // Random per-channel backpressure during the randomized phase
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) bus.AXIS_OUT_TREADY = NUM_CH'($urandom);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.AXIS_OUT_TREADY = '1;
    bus.AXIS_IN_TDATA = '0;
    bus.AXIS_IN_TVALID = 1'b0;
    bus.ashi_waddr = 0; bus.ashi_wdata = 0; bus.ashi_write = 1'b0;
    bus.ashi_raddr = 0; bus.ashi_read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_tvalid", bus.AXIS_OUT_TVALID, 0);
    chk("rst_in_tready", bus.AXIS_IN_TREADY, 0);
    chk("rst_tlast", bus.AXIS_OUT_TLAST, 2'b11);
    chk("rst_idle", {bus.ashi_widle, bus.ashi_ridle}, 2'b11);
    chk("rst_resp", {bus.ashi_wresp, bus.ashi_rresp}, 0);
    chk("rst_rdata", bus.ashi_rdata, 0);

    tbl[0]  = '{1'b1, 32'h80,  32'h2000,     2'd0, 32'h0};
    tbl[1]  = '{1'b0, 32'h00,  32'h0,        2'd0, 32'h2000};
    tbl[2]  = '{1'b0, 32'h180, 32'h0,        2'd0, 32'h2000};
    tbl[3]  = '{1'b0, 32'h08,  32'h0,        2'd0, 32'h3};
    tbl[4]  = '{1'b1, 32'h08,  32'hFFFF_FFFE, 2'd0, 32'h0};
    tbl[5]  = '{1'b0, 32'h08,  32'h0,        2'd0, 32'h2};
    tbl[6]  = '{1'b0, 32'h10,  32'h0,        2'd0, TO_DEF};
    tbl[7]  = '{1'b1, 32'h10,  32'd1234,     2'd0, 32'h0};
    tbl[8]  = '{1'b0, 32'h10,  32'h0,        2'd0, 32'd1234};
    tbl[9]  = '{1'b1, 32'h14,  32'h1,        2'd2, 32'h0};
    tbl[10] = '{1'b0, 32'h1C,  32'h0,        2'd2, 32'd1234};
    tbl[11] = '{1'b1, 32'h0C,  32'h7FFF_FFFF, 2'd0, 32'h0};
    tbl[12] = '{1'b0, 32'h0C,  32'h0,        2'd0, 32'h0};
    tbl[13] = '{1'b1, 32'h7C,  32'h5,        2'd2, 32'h0};
    tbl[14] = '{1'b1, 32'h08,  32'h3,        2'd0, 32'h0};
    tbl[15] = '{1'b0, 32'h00,  32'h0,        2'd0, 32'h2000};
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        reg_wr(tbl[i].a, tbl[i].d);
        chk($sformatf("tbl%0d_wresp", i), bus.ashi_wresp, tbl[i].resp);
      end else begin
        reg_rd(tbl[i].a, rv, rr);
        chk($sformatf("tbl%0d_rresp", i), rr, tbl[i].resp);
        chk($sformatf("tbl%0d_rdata", i), rv, tbl[i].rd);
      end
    end

    // Basic broadcast write, one-cycle TVALID with both channels ready
    wait_idle();
    wr_strobe(32'h4, 32'h55);
    get_req(req_d, req_v, req_cyc, req_stable);
    chk("s1_tvalid", req_v, 2'b11);
    chk("s1_tdata_lo", req_d[63:0], 64'h00000055_00002000);
    chk("s1_tdata", req_d, exp_pkt(32'h2000, 32'h55, 1'b0, 8'd1));
    chk("s1_tvalid_cycles", req_cyc, 1);
    chk("s1_in_tready", bus.AXIS_IN_TREADY, 1);
    send_resp(8'd1, 3'd0, 32'h0);
    wait_idle();
    chk("s1_wresp", bus.ashi_wresp, 0);
    reg_rd(32'h0C, rv, rr);
    chk("s1_status", rv, 32'h0001_0000);

    // Single-channel mask with backpressure on that channel
    reg_wr(32'h08, 32'h2);
    bus.AXIS_OUT_TREADY = 2'b01;
    wr_strobe(32'h4, 32'hAA);
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.AXIS_OUT_TVALID !== 2'b10) flag = 1'b0;
      if (bus.AXIS_OUT_TDATA !== exp_pkt(32'h2000, 32'hAA, 1'b0, 8'd2)) flag = 1'b0;
      if (bus.AXIS_IN_TREADY !== 1'b0) flag = 1'b0;
      @(negedge clk);
    end
    chk("s2_hold_stable", flag, 1);
    bus.AXIS_OUT_TREADY = 2'b11;
    @(negedge clk);
    chk("s2_tvalid_after", bus.AXIS_OUT_TVALID, 0);
    chk("s2_in_tready_after", bus.AXIS_IN_TREADY, 1);
    send_resp(8'd2, 3'd0, 32'h0);
    reg_wr(32'h08, 32'h3);

    // Stale response followed by the matching one
    wait_idle();
    rd_strobe(32'h4);
    get_req(req_d, req_v, req_cyc, req_stable);
    chk("s3_tdata", req_d, exp_pkt(32'h2000, 32'h0, 1'b1, 8'd3));
    send_resp(8'd0, 3'd0, 32'h1111_1111);
    chk("s3_still_waiting", bus.AXIS_IN_TREADY, 1);
    send_resp(8'd3, 3'd0, 32'hCAFE_F00D);
    wait_idle();
    chk("s3_rdata", bus.ashi_rdata, 32'hCAFE_F00D);
    chk("s3_rresp", bus.ashi_rresp, 0);
    reg_rd(32'h0C, rv, rr);
    chk("s3_status", rv, 32'h0003_0200);

    // Response timeout
    reg_wr(32'h10, 32'd10);
    rd_strobe(32'h4);
    get_req(req_d, req_v, req_cyc, req_stable);
    cnt = 0;
    while (bus.AXIS_IN_TREADY && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("s4_wait_cycles", cnt, 10);
    wait_idle();
    chk("s4_rresp", bus.ashi_rresp, 2);
    chk("s4_rdata", bus.ashi_rdata, 32'hDEAD_DEAD);
    reg_rd(32'h0C, rv, rr);
    chk("s4_sticky_set", rv[9:8], 2'b11);
    reg_wr(32'h0C, 32'h8000_0000);
    reg_rd(32'h0C, rv, rr);
    chk("s4_sticky_clr", rv[9:8], 2'b00);
    reg_wr(32'h10, 32'd0);

    // Preload strobes during an active write collapse into one request
    wait_idle();
    bus.AXIS_OUT_TREADY = 2'b00;
    wr_strobe(32'h4, 32'h77);
    repeat (3) begin
      preload_complete = 1'b1;
      @(negedge clk);
      preload_complete = 1'b0;
      @(negedge clk);
    end
    bus.AXIS_OUT_TREADY = 2'b11;
    get_req(req_d, req_v, req_cyc, req_stable);
    chk("s5_write_pkt", req_d, exp_pkt(32'h2000, 32'h77, 1'b0, 8'd5));
    send_resp(8'd5, 3'd0, 32'h0);
    get_req(req_d, req_v, req_cyc, req_stable);
    chk("s5_preload_pkt", req_d, exp_pkt(32'h1000, 32'hF, 1'b0, 8'd6));
    send_resp(8'd6, 3'd2, 32'h0);
    wait_idle();
    chk("s5_wresp_kept", bus.ashi_wresp, 0);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.AXIS_OUT_TVALID != '0) flag = 1'b1;
    end
    chk("s5_no_second_preload", flag, 0);
    reg_rd(32'h0C, rv, rr);
    chk("s5_status", rv, 32'h0006_0002);

    // Empty mask, then reset in the middle of SEND
    reg_wr(32'h08, 32'h0);
    wr_strobe(32'h4, 32'h1);
    flag = 1'b0;
    repeat (5) begin
      if (bus.AXIS_OUT_TVALID != '0) flag = 1'b1;
      @(negedge clk);
    end
    chk("s6_no_tvalid", flag, 0);
    chk("s6_wresp", bus.ashi_wresp, 2);
    reg_wr(32'h08, 32'h3);
    bus.AXIS_OUT_TREADY = 2'b00;
    wr_strobe(32'h4, 32'h2);
    chk("s6_in_send", bus.AXIS_OUT_TVALID, 2'b11);
    chk("s6_tag_no_skip", bus.AXIS_OUT_TDATA[79:72], 8'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_rst_tvalid", bus.AXIS_OUT_TVALID, 0);
    chk("s6_rst_in_tready", bus.AXIS_IN_TREADY, 0);
    reset = 1'b0;
    bus.AXIS_OUT_TREADY = 2'b11;
    reg_rd(32'h08, rv, rr);
    chk("s6_rst_mask", rv, 32'h3);
    reg_rd(32'h10, rv, rr);
    chk("s6_rst_timeout", rv, TO_DEF);
    model_reset();
    m_rdata = TO_DEF;

    // Randomized operations against the reference model
    rand_ready = 1'b1;
    for (int it = 0; it < 200; it++) begin
      int op;
      int idx;
      bit rd;
      op = $urandom_range(0, 9);
      rnd = $urandom;
      d = $urandom;
      if (op == 0) begin
        reg_wr(rnd & 32'hFFFF_FF80, d);
        m_addr = d; m_wresp = 0;
        chk("rnd_wr_addr", bus.ashi_wresp, m_wresp);
      end else if (op == 1) begin
        reg_wr((rnd & 32'hFFFF_FF80) | 32'h8, d);
        m_mask = d[NUM_CH-1:0]; m_wresp = 0;
        chk("rnd_wr_mask", bus.ashi_wresp, m_wresp);
      end else if (op == 2) begin
        reg_wr(32'h0C, d);
        if (d[31]) begin m_to = 0; m_stale = 0; end
        m_wresp = 0;
        chk("rnd_wr_status", bus.ashi_wresp, m_wresp);
      end else if (op == 3) begin
        d = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'($urandom_range(200, 5000));
        reg_wr(32'h10, d);
        m_timeout = d; m_wresp = 0;
        chk("rnd_wr_timeout", bus.ashi_wresp, m_wresp);
      end else if (op == 4) begin
        idx = $urandom_range(5, 31);
        reg_wr((rnd & 32'hFFFF_FF80) | (32'(idx) << 2), d);
        m_wresp = 2;
        chk("rnd_wr_bad", bus.ashi_wresp, m_wresp);
      end else if (op == 5) begin
        idx = $urandom_range(0, 31);
        if (idx == 1) idx = 0;
        reg_rd((rnd & 32'hFFFF_FF80) | (32'(idx) << 2), rv, rr);
        m_rresp = 0;
        case (idx)
          0: m_rdata = m_addr;
          2: m_rdata = 32'(m_mask);
          3: m_rdata = m_status();
          4: m_rdata = m_timeout;
          default: m_rresp = 2;
        endcase
        chk($sformatf("rnd_rd%0d_rresp", idx), rr, m_rresp);
        chk($sformatf("rnd_rd%0d_rdata", idx), rv, m_rdata);
      end else begin
        rd = ($urandom_range(0, 1) == 1);
        wait_idle();
        if (rd) rd_strobe(32'h4); else wr_strobe(32'h4, d);
        if (m_mask == '0) begin
          if (rd) begin m_rresp = 2; m_rdata = 0; end else m_wresp = 2;
        end else begin
          m_tag = m_tag + 8'd1;
          get_req(req_d, req_v, req_cyc, req_stable);
          chk("rnd_req_tvalid", req_v, m_mask);
          chk("rnd_req_tdata", req_d, exp_pkt(m_addr, d, rd, m_tag));
          chk("rnd_req_stable", req_stable, 1);
          if ($urandom_range(0, 2) == 0) begin
            send_resp(m_tag ^ 8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), $urandom);
            m_stale = 1;
          end
          rr = 2'($urandom_range(0, 3));
          a = $urandom;
          send_resp(m_tag, {1'b0, rr}, a);
          m_sresp = {1'b0, rr};
          m_stag = m_tag;
          if (rd) begin m_rresp = rr; m_rdata = a; end else m_wresp = rr;
        end
        wait_idle();
        if (rd) begin
          chk("rnd_px_rresp", bus.ashi_rresp, m_rresp);
          chk("rnd_px_rdata", bus.ashi_rdata, m_rdata);
        end else begin
          chk("rnd_px_wresp", bus.ashi_wresp, m_wresp);
        end
      end
    end
    rand_ready = 1'b0;
    bus.AXIS_OUT_TREADY = 2'b11;
    reg_rd(32'h0C, rv, rr);
    chk("rnd_final_status", rv, m_status());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_proxy_mc.md
Name: axi_proxy_mc

Overview:
Parametrised, multi-channel successor to the single-request AXI proxy. Translates AXI4-Lite slave-handler (ASHI) register accesses and the preload strobe into one-beat AXI-Stream request packets, broadcast to NUM_CH ECD links selected by a channel mask. It then waits for a tagged response packet. Adds request tagging, stale-response discard, a programmable response timeout, a sticky status register, and preload requests that are queued rather than dropped while the block is busy.

Parameters:
NUM_CH, 2, number of outgoing request streams
OUT_W, 512, request TDATA width (>=88)
IN_W, 256, response TDATA width (>=88)
PKT_TYPE, 8'h01, packet-type byte placed in request TDATA[OUT_W-1:OUT_W-8]
TIMEOUT_DEFAULT, 32'd1_000_000, reset value of TIMEOUT register (cycles)
PRELOAD_ADDR, 32'h0000_1000, AXI address of preload write
PRELOAD_VALU, 32'h0000_000F, data value of preload write

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
preload_complete  in  1  one-cycle strobe: issue preload write
AXIS_OUT_TDATA  out  OUT_W  request packet, shared by all channels
AXIS_OUT_TVALID  out  NUM_CH  per-channel valid
AXIS_OUT_TLAST  out  NUM_CH  tied all-ones (one-beat packets)
AXIS_OUT_TREADY  in  NUM_CH  per-channel ready
AXIS_IN_TDATA  in  IN_W  response packet
AXIS_IN_TVALID  in  1  response valid
AXIS_IN_TREADY  out  1  response ready
ashi_waddr  in  32  write address
ashi_wdata  in  32  write data
ashi_write  in  1  write request strobe
ashi_wresp  out  2  write response (OKAY=0, SLVERR=2)
ashi_widle  out  1  write side idle
ashi_raddr  in  32  read address
ashi_read  in  1  read request strobe
ashi_rdata  out  32  read data
ashi_rresp  out  2  read response
ashi_ridle  out  1  read side idle

Behaviour:
- Register index = (addr & 7'h7F) >> 2.
  - 0 ADDR: RW.
  - 1 PROXY: write issues a stream write; read issues a stream read.
  - 2 CH_MASK: RW, low NUM_CH bits, reset all-ones.
  - 3 STATUS: RO. [2:0] last response, [8] sticky timeout, [9] sticky stale-discard, [23:16] last tag. Writing STATUS with bit 31 set clears both sticky bits; all other STATUS writes return OKAY with no effect.
  - 4 TIMEOUT: RW; 0 disables the timeout.
  - Any other index: SLVERR, no side effects.
- Request TDATA layout: [31:0] addr, [63:32] data, [64] mode (0=write, 1=read), [79:72] tag, top byte PKT_TYPE, all other bits 0. For reads, data = 0.
- Response TDATA layout: [63:32] data, [66:64] resp, [79:72] tag.
- widle = !ashi_write & state==IDLE; ridle = !ashi_read & state==IDLE. wresp, rresp and rdata are stable whenever the corresponding idle flag is high.
- Non-proxy register accesses complete in the IDLE cycle they arrive; the block stays in IDLE.
- FSM states: IDLE, SEND, WAIT_RESP.
- IDLE priority: ashi_write > ashi_read > preload pending.
  - Proxy access with CH_MASK & all-ones == 0: immediate SLVERR, rdata=0, no packet sent.
  - Otherwise: tag increments (mod 256) and TDATA is loaded. TVALID[i] <= CH_MASK[i]. Go to SEND.
- SEND: each TVALID[i] drops on its own handshake. TDATA is stable throughout SEND. When all TVALID are 0: TREADY <= 1, clear the timeout counter, go to WAIT_RESP. SEND never times out.
- WAIT_RESP:
  - On handshake with tag == current tag: TREADY <= 0, latch resp (and data for reads), go to IDLE.
  - On handshake with mismatched tag: discard the packet, set stale sticky bit, keep waiting.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no match: TREADY <= 0, resp = SLVERR, rdata = 32'hDEAD_DEAD, set timeout sticky bit, go to IDLE.
  - A matching handshake in the same cycle as expiry wins over the timeout.
- Preload:
  - A preload_complete strobe sets a pending flag, regardless of state.
  - Servicing a preload clears the flag. If a new strobe arrives in the same cycle, the flag stays set.
  - A preload response updates STATUS only; ashi_wresp and ashi_rresp are unchanged.
  - Multiple strobes while pending collapse into one request.
- Reset (any state, mid-packet included): all TVALID=0, TREADY=0, state IDLE, tag=0, CH_MASK all-ones, TIMEOUT=TIMEOUT_DEFAULT, ADDR=0, STATUS=0, pending=0, wresp=rresp=OKAY, rdata=0.

Test Plan:
- ADDR=0x2000, write PROXY=0x55, NUM_CH=2, both TREADY high -> both TVALID high 1 cycle, TDATA[63:0]=0x00000055_00002000, tag=1. Response tag=1 resp=0 -> wresp OKAY, STATUS[23:16]=1.
- CH_MASK=2'b10, TREADY[1] held low 5 cycles -> TVALID[0] stays 0, TVALID[1] held with stable TDATA; AXIS_IN_TREADY rises only after the ch1 handshake.
- Read PROXY, stale response tag=0 then response tag=1 data=0xCAFEF00D -> first packet discarded, STATUS[9]=1, rdata=0xCAFEF00D, rresp OKAY.
- TIMEOUT=10, no response -> exactly 10 cycles in WAIT_RESP, then rresp=SLVERR, rdata=0xDEADDEAD, STATUS[8]=1. STATUS write 0x80000000 clears bit 8.
- preload_complete pulsed 3x during an active write -> exactly one preload packet (addr 0x1000, data 0xF) issued after the write completes; ashi_wresp unchanged.
- CH_MASK=0 write PROXY -> SLVERR, no TVALID. Reset asserted in SEND -> all TVALID 0 next cycle, CH_MASK reads 2'b11.
